ctrl_pipeline: RTL and testbench

- Consumer side of the main control decoder's output bundle in the 5-stage pipelined core.
- Carries the decoded control word from ID through the EX, MEM and WB stage registers.
- Detects load-use hazards and inserts bubbles; applies branch/jump flushes.
- Drives the PC/IF-ID write-enable and IF-ID flush, and keeps stall/flush event counters.

---
 rtl/ctrl_pipeline_if.sv | 37 +++
 rtl/ctrl_pipeline.sv | 78 +++++++
 tb/tb_ctrl_pipeline.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipeline_if.sv
// Control-pipeline bundle: ID-stage decode inputs, redirect, and the per-stage
// control words, enables and event counters the pipeline drives back.
interface ctrl_pipeline_if #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
);
    logic             id_valid;
    logic [9:0]       id_ctrl;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_redirect;
    logic             pc_write;
    logic             if_flush;
    logic [9:0]       ex_ctrl;
    logic [9:0]       mem_ctrl;
    logic [9:0]       wb_ctrl;
    logic [REG_W-1:0] ex_rd;
    logic [REG_W-1:0] mem_rd;
    logic [REG_W-1:0] wb_rd;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, ex_redirect,
        input  pc_write, if_flush, ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, ex_redirect,
        output pc_write, if_flush, ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// Carries decoded control words ID->EX->MEM->WB, inserts load-use bubbles,
// applies branch/jump flushes and keeps saturating stall/flush counters.
module ctrl_pipeline #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic           clk,
    input  logic           rstn,
    ctrl_pipeline_if.slave bus
);
    localparam int MEM_READ_BIT = 6;

    logic [9:0]       ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, wb_ctrl_q;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, wb_rd_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             hazard;
    logic             redirect;
    logic             rs1_match;
    logic             rs2_match;

    always_comb begin
        redirect  = bus.ex_redirect;
        rs1_match = bus.id_use_rs1 && (bus.id_rs1 == ex_rd_q);
        rs2_match = bus.id_use_rs2 && (bus.id_rs2 == ex_rd_q);
        // x0 is never a real destination, so a load to it cannot stall.
        hazard    = bus.id_valid && ex_ctrl_q[MEM_READ_BIT] && (ex_rd_q != '0)
                    && (rs1_match || rs2_match);

        ex_ctrl_d   = bus.id_ctrl;
        ex_rd_d     = bus.id_rd;
        if (redirect || hazard || !bus.id_valid) begin
            ex_ctrl_d = '0;
            ex_rd_d   = '0;
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        // Redirect wins: a simultaneous hazard is squashed, not counted as a stall.
        if (redirect) begin
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (hazard) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ex_ctrl_q   <= '0;
            mem_ctrl_q  <= '0;
            wb_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            mem_rd_q    <= '0;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            mem_ctrl_q  <= ex_ctrl_q;
            mem_rd_q    <= ex_rd_q;
            wb_ctrl_q   <= mem_ctrl_q;
            wb_rd_q     <= mem_rd_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_write  = !hazard || redirect;
    assign bus.if_flush  = redirect;
    assign bus.ex_ctrl   = ex_ctrl_q;
    assign bus.mem_ctrl  = mem_ctrl_q;
    assign bus.wb_ctrl   = wb_ctrl_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed scenarios plus randomized
// traffic compared against a queue-based pipeline model.
module tb_ctrl_pipeline;
    localparam logic [9:0] RTYPE = 10'b00_000_10_001;
    localparam logic [9:0] LOAD  = 10'b00_011_00_011;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    ctrl_pipeline_if #(.CNT_W(16), .REG_W(5)) bus ();
    ctrl_pipeline_if #(.CNT_W(2),  .REG_W(5)) bus2 ();

    ctrl_pipeline #(.CNT_W(16), .REG_W(5)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
    ctrl_pipeline #(.CNT_W(2),  .REG_W(5)) dut2 (.clk(clk), .rstn(rstn), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    logic [9:0] m_ctrl[3];
    logic [4:0] m_rd[3];
    int         m_stall;
    int         m_flush;

    function automatic bit m_hazard();
        bit reads_rs1;
        bit reads_rs2;
        if (!bus.id_valid || m_rd[0] == 5'd0) return 1'b0;
        if (m_ctrl[0][6] != 1'b1) return 1'b0;
        reads_rs1 = bus.id_use_rs1 && (bus.id_rs1 == m_rd[0]);
        reads_rs2 = bus.id_use_rs2 && (bus.id_rs2 == m_rd[0]);
        return reads_rs1 || reads_rs2;
    endfunction

    task automatic drive(input bit v, input logic [9:0] c, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input bit u1,
                         input bit u2, input bit redir);
        bus.id_valid    = v;
        bus.id_ctrl     = c;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_use_rs1  = u1;
        bus.id_use_rs2  = u2;
        bus.ex_redirect = redir;
        #1;
    endtask

    // Advances model and DUT by one clock; comparisons stay in the tests.
    task automatic tick();
        bit hz;
        hz = m_hazard();
        if (!rstn) begin
            for (int i = 0; i < 3; i++) begin
                m_ctrl[i] = '0;
                m_rd[i]   = '0;
            end
            m_stall = 0;
            m_flush = 0;
        end else begin
            m_ctrl[2] = m_ctrl[1];
            m_rd[2]   = m_rd[1];
            m_ctrl[1] = m_ctrl[0];
            m_rd[1]   = m_rd[0];
            if (bus.ex_redirect || hz || !bus.id_valid) begin
                m_ctrl[0] = '0;
                m_rd[0]   = '0;
            end else begin
                m_ctrl[0] = bus.id_ctrl;
                m_rd[0]   = bus.id_rd;
            end
            if (bus.ex_redirect) m_flush = (m_flush >= 65535) ? 65535 : m_flush + 1;
            else if (hz)         m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive($urandom_range(0, 1), 10'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            bus2.ex_redirect = $urandom_range(0, 1);
            tick();
        end
        bus2.ex_redirect = 1'b0;
        drive(0, '0, '0, '0, '0, 0, 0, 0);
        total++;
        if ({bus.ex_ctrl, bus.mem_ctrl, bus.wb_ctrl} !== 30'd0) begin
            bad++;
            $display("FAIL reset_ctrl got=%h/%h/%h exp=0", bus.ex_ctrl, bus.mem_ctrl, bus.wb_ctrl);
        end
        total++;
        if ({bus.ex_rd, bus.mem_rd, bus.wb_rd} !== 15'd0) begin
            bad++;
            $display("FAIL reset_rd got=%0d/%0d/%0d exp=0", bus.ex_rd, bus.mem_rd, bus.wb_rd);
        end
        total++;
        if (bus.pc_write !== 1'b1 || bus.if_flush !== 1'b0) begin
            bad++;
            $display("FAIL reset_pc got pc_write=%b if_flush=%b exp 1/0", bus.pc_write, bus.if_flush);
        end
        total++;
        if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0 || bus2.flush_cnt !== 2'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0", bus.stall_cnt, bus.flush_cnt, bus2.flush_cnt);
        end
        rstn = 1'b1;
    endtask

    task automatic test_passthrough();
        drive(1, RTYPE, 5'd1, 5'd2, 5'd5, 1, 1, 0);
        tick();
        drive(0, '0, '0, '0, '0, 0, 0, 0);
        total++;
        if (bus.ex_ctrl !== RTYPE || bus.ex_rd !== 5'd5) begin
            bad++;
            $display("FAIL pass_ex got=%h rd=%0d exp=%h rd=5", bus.ex_ctrl, bus.ex_rd, RTYPE);
        end
        tick();
        total++;
        if (bus.mem_ctrl !== RTYPE || bus.mem_rd !== 5'd5 || bus.ex_ctrl !== 10'd0) begin
            bad++;
            $display("FAIL pass_mem got=%h rd=%0d ex=%h exp=%h rd=5 ex=0", bus.mem_ctrl, bus.mem_rd, bus.ex_ctrl, RTYPE);
        end
        tick();
        total++;
        if (bus.wb_ctrl !== RTYPE || bus.wb_rd !== 5'd5 || bus.pc_write !== 1'b1) begin
            bad++;
            $display("FAIL pass_wb got=%h rd=%0d pcw=%b exp=%h rd=5 pcw=1", bus.wb_ctrl, bus.wb_rd, bus.pc_write, RTYPE);
        end
    endtask

    task automatic test_load_use();
        int s0;
        s0 = m_stall;
        drive(1, LOAD, 5'd2, 5'd0, 5'd7, 1, 0, 0);
        tick();
        drive(1, RTYPE, 5'd1, 5'd7, 5'd9, 1, 1, 0);
        total++;
        if (bus.pc_write !== 1'b0 || bus.if_flush !== 1'b0) begin
            bad++;
            $display("FAIL lu_stall got pcw=%b flush=%b exp 0/0", bus.pc_write, bus.if_flush);
        end
        tick();
        total++;
        if (bus.ex_ctrl !== 10'd0 || bus.stall_cnt !== 16'(s0 + 1) || bus.pc_write !== 1'b1) begin
            bad++;
            $display("FAIL lu_bubble got ex=%h stall=%0d pcw=%b exp ex=0 stall=%0d pcw=1",
                     bus.ex_ctrl, bus.stall_cnt, bus.pc_write, s0 + 1);
        end
        tick();
        drive(0, '0, '0, '0, '0, 0, 0, 0);
        total++;
        if (bus.ex_ctrl !== RTYPE || bus.ex_rd !== 5'd9 || bus.wb_ctrl !== LOAD) begin
            bad++;
            $display("FAIL lu_release got ex=%h rd=%0d wb=%h exp ex=%h rd=9 wb=%h",
                     bus.ex_ctrl, bus.ex_rd, bus.wb_ctrl, RTYPE, LOAD);
        end
    endtask

    task automatic test_x0_unused();
        drive(1, LOAD, 5'd1, 5'd0, 5'd0, 1, 0, 0);
        tick();
        drive(1, RTYPE, 5'd0, 5'd4, 5'd6, 1, 1, 0);
        total++;
        if (bus.pc_write !== 1'b1) begin
            bad++;
            $display("FAIL x0_nostall got pcw=%b exp 1", bus.pc_write);
        end
        drive(1, LOAD, 5'd1, 5'd0, 5'd3, 1, 0, 0);
        tick();
        drive(1, RTYPE, 5'd1, 5'd3, 5'd6, 1, 0, 0);
        total++;
        if (bus.pc_write !== 1'b1) begin
            bad++;
            $display("FAIL unused_rs2 got pcw=%b exp 1", bus.pc_write);
        end
        tick();
        total++;
        if (bus.ex_ctrl !== RTYPE || bus.stall_cnt !== 16'(m_stall)) begin
            bad++;
            $display("FAIL unused_pass got ex=%h stall=%0d exp ex=%h stall=%0d", bus.ex_ctrl, bus.stall_cnt, RTYPE, m_stall);
        end
    endtask

    task automatic test_redirect_hazard();
        int s0;
        int f0;
        drive(1, LOAD, 5'd1, 5'd0, 5'd7, 1, 0, 0);
        tick();
        s0 = m_stall;
        f0 = m_flush;
        drive(1, RTYPE, 5'd7, 5'd7, 5'd8, 1, 1, 1);
        total++;
        if (bus.pc_write !== 1'b1 || bus.if_flush !== 1'b1) begin
            bad++;
            $display("FAIL redir_comb got pcw=%b flush=%b exp 1/1", bus.pc_write, bus.if_flush);
        end
        tick();
        drive(0, '0, '0, '0, '0, 0, 0, 1);
        total++;
        if (bus.ex_ctrl !== 10'd0 || bus.flush_cnt !== 16'(f0 + 1) || bus.stall_cnt !== 16'(s0)) begin
            bad++;
            $display("FAIL redir_cnt got ex=%h flush=%0d stall=%0d exp ex=0 flush=%0d stall=%0d",
                     bus.ex_ctrl, bus.flush_cnt, bus.stall_cnt, f0 + 1, s0);
        end
        tick();
        total++;
        if (bus.flush_cnt !== 16'(f0 + 2)) begin
            bad++;
            $display("FAIL redir_novalid got flush=%0d exp %0d", bus.flush_cnt, f0 + 2);
        end
    endtask

    task automatic test_saturation();
        int exp;
        drive(0, '0, '0, '0, '0, 0, 0, 0);
        bus2.id_valid    = 1'b0;
        bus2.id_ctrl     = '0;
        bus2.id_rs1      = '0;
        bus2.id_rs2      = '0;
        bus2.id_rd       = '0;
        bus2.id_use_rs1  = 1'b0;
        bus2.id_use_rs2  = 1'b0;
        bus2.ex_redirect = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp = (i > 3) ? 3 : i;
            total++;
            if (bus2.flush_cnt !== 2'(exp)) begin
                bad++;
                $display("FAIL sat_step%0d got=%0d exp=%0d", i, bus2.flush_cnt, exp);
            end
        end
        bus2.ex_redirect = 1'b0;
    endtask

    task automatic test_random();
        bit exp_pcw;
        for (int n = 0; n < 400; n++) begin
            rstn = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) != 0) ? LOAD : 10'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0);
            exp_pcw = !m_hazard() || bus.ex_redirect;
            total++;
            if (bus.pc_write !== exp_pcw || bus.if_flush !== bus.ex_redirect) begin
                bad++;
                $display("FAIL rnd_comb[%0d] got pcw=%b flush=%b exp pcw=%b flush=%b",
                         n, bus.pc_write, bus.if_flush, exp_pcw, bus.ex_redirect);
            end
            tick();
            total++;
            if (bus.ex_ctrl !== m_ctrl[0] || bus.mem_ctrl !== m_ctrl[1] || bus.wb_ctrl !== m_ctrl[2]
                || bus.ex_rd !== m_rd[0] || bus.mem_rd !== m_rd[1] || bus.wb_rd !== m_rd[2]) begin
                bad++;
                $display("FAIL rnd_stages[%0d] got %h:%0d %h:%0d %h:%0d exp %h:%0d %h:%0d %h:%0d", n,
                         bus.ex_ctrl, bus.ex_rd, bus.mem_ctrl, bus.mem_rd, bus.wb_ctrl, bus.wb_rd,
                         m_ctrl[0], m_rd[0], m_ctrl[1], m_rd[1], m_ctrl[2], m_rd[2]);
            end
            total++;
            if (bus.stall_cnt !== 16'(m_stall) || bus.flush_cnt !== 16'(m_flush)) begin
                bad++;
                $display("FAIL rnd_cnt[%0d] got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                         n, bus.stall_cnt, bus.flush_cnt, m_stall, m_flush);
            end
        end
        rstn = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        bus2.id_valid    = 1'b0;
        bus2.id_ctrl     = '0;
        bus2.id_rs1      = '0;
        bus2.id_rs2      = '0;
        bus2.id_rd       = '0;
        bus2.id_use_rs1  = 1'b0;
        bus2.id_use_rs2  = 1'b0;
        bus2.ex_redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_ctrl[i] = '0;
            m_rd[i]   = '0;
        end
        m_stall = 0;
        m_flush = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_passthrough();
        test_load_use();
        test_x0_unused();
        test_redirect_hazard();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
